// File: rtl/ysyx_22050499_mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory arbiter: FSM encodings, address map,
// one-hot slave selects and the timeout error pattern (ARB_TIMEOUT_EN build).
package ysyx_22050499_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [31:0] SRAM_BASE  = 32'h8000_0000;
    localparam logic [31:0] SRAM_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] UART_BASE  = 32'hA000_03F8;
    localparam logic [31:0] UART_LIMIT = 32'hA000_03FF;
    localparam logic [31:0] CLINT_BASE  = 32'hA000_0048;
    localparam logic [31:0] CLINT_LIMIT = 32'hA000_004F;

    localparam logic [3:0] DEC_SRAM  = 4'b0001;
    localparam logic [3:0] DEC_UART  = 4'b0010;
    localparam logic [3:0] DEC_CLINT = 4'b0100;
    localparam logic [3:0] DEC_NONE  = 4'b1000;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/ysyx_22050499_mem_arbiter_addr_decode.sv
// Combinational address decoder: 32-bit address to one-hot slave select,
// DEC_NONE when the address hits no mapped device.
module ysyx_22050499_addr_decode
    import ysyx_22050499_mem_arbiter_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [3:0]  o_sel
);

    always_comb begin
        o_sel = DEC_NONE;
        if (i_addr >= SRAM_BASE && i_addr <= SRAM_LIMIT)
            o_sel = DEC_SRAM;
        else if (i_addr >= UART_BASE && i_addr <= UART_LIMIT)
            o_sel = DEC_UART;
        else if (i_addr >= CLINT_BASE && i_addr <= CLINT_LIMIT)
            o_sel = DEC_CLINT;
    end

endmodule

// File: rtl/ysyx_22050499_mem_arbiter.sv
// Two-requester (IFU/LSU) round-robin memory arbiter with a single outstanding
// transaction. Define ARB_TIMEOUT_EN to bound the downstream response wait.
module ysyx_22050499_mem_arbiter
    import ysyx_22050499_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rsp_rdata,
    output logic        ifu_rsp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_addr,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wstrb,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_rdata,
    output logic        lsu_rsp_err,
    output logic        m_req_valid,
    input  logic        m_req_ready,
    output logic        m_req_wen,
    output logic [31:0] m_req_addr,
    output logic [31:0] m_req_wdata,
    output logic [3:0]  m_req_wstrb,
    input  logic        m_rsp_valid,
    input  logic [31:0] m_rsp_rdata,
    output logic [3:0]  xbar_decode
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    logic [1:0]  r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_err;
`ifdef ARB_TIMEOUT_EN
    logic [7:0]  r_cnt;
`endif

    logic        w_idle;
    logic        w_gnt_lsu;
    logic        w_gnt_ifu;
    logic [31:0] w_win_addr;
    logic [3:0]  w_win_sel;
    logic [3:0]  w_lat_sel;
    logic        w_resp;

    // On a tie the requester that did not win last time takes the bus.
    assign w_idle     = (r_state == ST_IDLE) && !reset;
    assign w_gnt_lsu  = w_idle && lsu_req_valid && (!ifu_req_valid || r_last_grant == OWN_IFU);
    assign w_gnt_ifu  = w_idle && ifu_req_valid && !w_gnt_lsu;
    assign w_win_addr = w_gnt_lsu ? lsu_req_addr : ifu_req_addr;

    ysyx_22050499_addr_decode u_dec_win (.i_addr(w_win_addr), .o_sel(w_win_sel));
    ysyx_22050499_addr_decode u_dec_lat (.i_addr(r_addr),     .o_sel(w_lat_sel));

    assign ifu_req_ready = w_gnt_ifu;
    assign lsu_req_ready = w_gnt_lsu;

    assign m_req_valid = (r_state == ST_ISSUE);
    assign m_req_wen   = r_wen;
    assign m_req_addr  = r_addr;
    assign m_req_wdata = r_wdata;
    assign m_req_wstrb = r_wstrb;
    assign xbar_decode = (r_state == ST_ISSUE || r_state == ST_WAIT) ? w_lat_sel : 4'b0000;

    assign w_resp        = (r_state == ST_RESP);
    assign ifu_rsp_valid = w_resp && (r_owner == OWN_IFU);
    assign ifu_rsp_rdata = ifu_rsp_valid ? r_rdata : 32'h0;
    assign ifu_rsp_err   = ifu_rsp_valid & r_err;
    assign lsu_rsp_valid = w_resp && (r_owner == OWN_LSU);
    assign lsu_rsp_rdata = lsu_rsp_valid ? r_rdata : 32'h0;
    assign lsu_rsp_err   = lsu_rsp_valid & r_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= OWN_IFU;
            r_owner      <= OWN_IFU;
            r_wen        <= 1'b0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_wstrb      <= 4'h0;
            r_rdata      <= 32'h0;
            r_err        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt        <= 8'h0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_lsu || w_gnt_ifu) begin
                        r_owner      <= w_gnt_lsu;
                        r_last_grant <= w_gnt_lsu;
                        r_addr       <= w_win_addr;
                        r_wen        <= w_gnt_lsu & lsu_req_wen;
                        r_wdata      <= w_gnt_lsu ? lsu_req_wdata : 32'h0;
                        r_wstrb      <= w_gnt_lsu ? lsu_req_wstrb : 4'h0;
                        r_rdata      <= 32'h0;
                        r_err        <= (w_win_sel == DEC_NONE);
                        r_state      <= (w_win_sel == DEC_NONE) ? ST_RESP : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_req_ready) begin
                        if (m_rsp_valid) begin
                            r_rdata <= r_wen ? 32'h0 : m_rsp_rdata;
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                        end
`ifdef ARB_TIMEOUT_EN
                        r_cnt <= 8'h0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (m_rsp_valid) begin
                        r_rdata <= r_wen ? 32'h0 : m_rsp_rdata;
                        r_state <= ST_RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        r_rdata <= ERR_DATA;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050499_mem_arbiter.sv
// Directed self-checking bench for ysyx_22050499_mem_arbiter (both builds of ARB_TIMEOUT_EN).
module tb_ysyx_22050499_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rsp_rdata;
    logic        m_req_valid, m_req_ready, m_req_wen;
    logic [31:0] m_req_addr, m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic [3:0]  xbar_decode;

    int n_chk = 0;
    int n_fail = 0;

    ysyx_22050499_mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_wen(lsu_req_wen),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_wen(m_req_wen),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .xbar_decode(xbar_decode)
    );

    always #5 clock = ~clock;

    logic [143:0] all_out;
    assign all_out = {ifu_req_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
                      lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
                      m_req_valid, m_req_wen, m_req_addr, m_req_wdata, m_req_wstrb, xbar_decode};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = 32'h0;
        lsu_req_wdata = 32'h0; lsu_req_wstrb = 4'h0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_chk++;
        if (all_out !== 144'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
    endtask

    task automatic test_ifu_read();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0000;
        #1;
        n_chk++;
        if ({ifu_req_ready, lsu_req_ready, m_req_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL ifu_read_c0: got %b want 100", {ifu_req_ready, lsu_req_ready, m_req_valid});
        end
        tick();
        ifu_req_valid = 1'b0;
        m_req_ready = 1'b1; m_rsp_valid = 1'b1; m_rsp_rdata = 32'h1234_5678;
        #1;
        n_chk++;
        if ({m_req_valid, m_req_wen, m_req_addr, xbar_decode} !== {1'b1, 1'b0, 32'h8000_0000, 4'b0001}) begin
            n_fail++;
            $display("FAIL ifu_read_c1: got %b %b %h %b want 1 0 80000000 0001",
                     m_req_valid, m_req_wen, m_req_addr, xbar_decode);
        end
        tick();
        m_req_ready = 1'b0; m_rsp_valid = 1'b0;
        #1;
        n_chk++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata, lsu_rsp_valid, m_req_valid, xbar_decode} !==
            {1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL ifu_read_c2: got v=%b e=%b d=%h lsu=%b mv=%b x=%b want 1 0 12345678 0 0 0000",
                     ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata, lsu_rsp_valid, m_req_valid, xbar_decode);
        end
        tick();
        n_chk++;
        if (ifu_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ifu_read_c3: rsp_valid got %b want 0", ifu_rsp_valid);
        end
    endtask

    // One tie round: both requesters valid, expect the given winner, complete the transfer.
    task automatic tie_round(input logic exp_lsu, input int idx);
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0004;
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0100;
        #1;
        n_chk++;
        if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, ~exp_lsu}) begin
            n_fail++;
            $display("FAIL tie_grant%0d: got lsu/ifu ready %b%b want %b%b", idx,
                     lsu_req_ready, ifu_req_ready, exp_lsu, ~exp_lsu);
        end
        tick();
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        m_req_ready = 1'b1; m_rsp_valid = 1'b1; m_rsp_rdata = 32'h0000_0A00 + 32'(idx);
        tick();
        m_req_ready = 1'b0; m_rsp_valid = 1'b0;
        #1;
        n_chk++;
        if ({lsu_rsp_valid, ifu_rsp_valid} !== {exp_lsu, ~exp_lsu}) begin
            n_fail++;
            $display("FAIL tie_rsp%0d: got lsu/ifu rsp %b%b want %b%b", idx,
                     lsu_rsp_valid, ifu_rsp_valid, exp_lsu, ~exp_lsu);
        end
        tick();
    endtask

    task automatic test_arb_tie();
        do_reset();
        tie_round(1'b1, 0);
        tie_round(1'b0, 1);
        tie_round(1'b1, 2);
    endtask

    task automatic test_lsu_write_stall();
        logic [72:0] exp_req;
        exp_req = {1'b1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, 4'b0010};
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'hA000_03F8;
        lsu_req_wdata = 32'h0000_0041; lsu_req_wstrb = 4'b0001;
        #1;
        n_chk++;
        if (lsu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_accept: lsu_req_ready got %b want 1", lsu_req_ready);
        end
        tick();
        // Scramble the LSU inputs so only latched values can match.
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = 32'h1111_1111;
        lsu_req_wdata = 32'h2222_2222; lsu_req_wstrb = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            m_req_ready = (i == 3);
            #1;
            n_chk++;
            if ({m_req_wen, m_req_addr, m_req_wdata, m_req_wstrb, xbar_decode} !== exp_req || m_req_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_hold%0d: got v=%b w=%b a=%h d=%h s=%b x=%b want 1 1 a00003f8 00000041 0001 0010",
                         i, m_req_valid, m_req_wen, m_req_addr, m_req_wdata, m_req_wstrb, xbar_decode);
            end
            tick();
        end
        m_req_ready = 1'b0;
        #1;
        n_chk++;
        if ({m_req_valid, xbar_decode, lsu_rsp_valid} !== {1'b0, 4'b0010, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_wait: got mv=%b x=%b rv=%b want 0 0010 0", m_req_valid, xbar_decode, lsu_rsp_valid);
        end
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        m_rsp_valid = 1'b0;
        #1;
        n_chk++;
        if ({lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, ifu_rsp_valid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wr_rsp: got v=%b e=%b d=%h ifu=%b want 1 0 00000000 0",
                     lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, ifu_rsp_valid);
        end
        tick();
        n_chk++;
        if (lsu_rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_rsp_once: lsu_rsp_valid got %b want 0", lsu_rsp_valid);
        end
    endtask

    task automatic test_unmapped();
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h1000_0000;
        #1;
        n_chk++;
        if ({lsu_req_ready, m_req_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL unmap_accept: got ready=%b mv=%b want 1 0", lsu_req_ready, m_req_valid);
        end
        tick();
        lsu_req_valid = 1'b0;
        #1;
        n_chk++;
        if ({lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, m_req_valid, xbar_decode} !==
            {1'b1, 1'b1, 32'h0, 1'b0, 4'b0000}) begin
            n_fail++;
            $display("FAIL unmap_rsp: got v=%b e=%b d=%h mv=%b x=%b want 1 1 00000000 0 0000",
                     lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata, m_req_valid, xbar_decode);
        end
        tick();
    endtask

    task automatic test_decode_bounds();
        logic [31:0] addrs [6];
        logic [3:0]  sels  [6];
        addrs = '{32'h87FF_FFFF, 32'h8800_0000, 32'hA000_03FF, 32'hA000_03F7, 32'hA000_004F, 32'hA000_0050};
        sels  = '{4'b0001, 4'b1000, 4'b0010, 4'b1000, 4'b0100, 4'b1000};
        for (int i = 0; i < 6; i++) begin
            ifu_req_valid = 1'b1; ifu_req_addr = addrs[i];
            tick();
            ifu_req_valid = 1'b0;
            #1;
            n_chk++;
            if (sels[i] == 4'b1000) begin
                if ({m_req_valid, xbar_decode, ifu_rsp_valid, ifu_rsp_err} !== {1'b0, 4'b0000, 1'b1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL decode_%h: got mv=%b x=%b rv=%b e=%b want 0 0000 1 1", addrs[i],
                             m_req_valid, xbar_decode, ifu_rsp_valid, ifu_rsp_err);
                end
                tick();
            end else begin
                if ({m_req_valid, xbar_decode, ifu_rsp_valid} !== {1'b1, sels[i], 1'b0}) begin
                    n_fail++;
                    $display("FAIL decode_%h: got mv=%b x=%b rv=%b want 1 %b 0", addrs[i],
                             m_req_valid, xbar_decode, ifu_rsp_valid, sels[i]);
                end
                m_req_ready = 1'b1; m_rsp_valid = 1'b1;
                tick();
                m_req_ready = 1'b0; m_rsp_valid = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_timeout();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0010;
        tick();
        ifu_req_valid = 1'b0; m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            n_chk++;
            if ({m_req_valid, xbar_decode, ifu_rsp_valid} !== {1'b0, 4'b0001, 1'b0}) begin
                n_fail++;
                $display("FAIL wait_cycle%0d: got mv=%b x=%b rv=%b want 0 0001 0", i,
                         m_req_valid, xbar_decode, ifu_rsp_valid);
            end
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        n_chk++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL timeout_rsp: got v=%b e=%b d=%h want 1 1 deadbeef",
                     ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata);
        end
        tick();
`else
        n_chk++;
        if ({ifu_rsp_valid, xbar_decode} !== {1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL wait_persist: got rv=%b x=%b want 0 0001", ifu_rsp_valid, xbar_decode);
        end
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'h0000_CAFE;
        tick();
        m_rsp_valid = 1'b0;
        n_chk++;
        if ({ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata} !== {1'b1, 1'b0, 32'h0000_CAFE}) begin
            n_fail++;
            $display("FAIL late_rsp: got v=%b e=%b d=%h want 1 0 0000cafe",
                     ifu_rsp_valid, ifu_rsp_err, ifu_rsp_rdata);
        end
        tick();
`endif
        // A response arriving while idle must not produce a strobe.
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'h5555_5555;
        tick();
        m_rsp_valid = 1'b0;
        n_chk++;
        if ({ifu_rsp_valid, lsu_rsp_valid, m_req_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL stale_drop: got %b want 000", {ifu_rsp_valid, lsu_rsp_valid, m_req_valid});
        end
    endtask

    task automatic test_reset_mid();
        ifu_req_valid = 1'b1; ifu_req_addr = 32'h8000_0020;
        tick();
        ifu_req_valid = 1'b0; m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_rsp_valid = 1'b1; m_rsp_rdata = 32'h7777_7777;
        #1;
        n_chk++;
        if (all_out !== 144'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h want 0", all_out);
        end
        tick();
        m_rsp_valid = 1'b0;
        n_chk++;
        if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_norsp: got %b want 00", {ifu_rsp_valid, lsu_rsp_valid});
        end
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'hA000_0048;
        #1;
        n_chk++;
        if (lsu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_accept: got %b want 1", lsu_req_ready);
        end
        tick();
        lsu_req_valid = 1'b0;
        n_chk++;
        if ({m_req_valid, xbar_decode, m_req_addr} !== {1'b1, 4'b0100, 32'hA000_0048}) begin
            n_fail++;
            $display("FAIL post_reset_issue: got mv=%b x=%b a=%h want 1 0100 a0000048",
                     m_req_valid, xbar_decode, m_req_addr);
        end
        m_req_ready = 1'b1; m_rsp_valid = 1'b1; m_rsp_rdata = 32'h0000_0123;
        tick();
        m_req_ready = 1'b0; m_rsp_valid = 1'b0;
        n_chk++;
        if ({lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata} !== {1'b1, 1'b0, 32'h0000_0123}) begin
            n_fail++;
            $display("FAIL post_reset_rsp: got v=%b e=%b d=%h want 1 0 00000123",
                     lsu_rsp_valid, lsu_rsp_err, lsu_rsp_rdata);
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_ifu_read();
        test_arb_tie();
        test_lsu_write_stall();
        test_unmapped();
        test_decode_bounds();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_22050499_mem_arbiter.md
Name: ysyx_22050499_mem_arbiter

Overview:
Two-requester memory-bus arbiter and sequencer placed between the core's IFU/LSU and the device crossbar (SRAM, UART, CLINT).
- Grants one transaction at a time, using round-robin on ties.
- Latches the request and drives the shared downstream request channel.
- Produces the one-hot xbar_decode select.
- Returns the response to the owning requester.

Parameters:
TIMEOUT_CYCLES, 16, downstream response wait limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted (1-cycle pulse)
ifu_req_addr  in  32  IFU fetch address
ifu_rsp_valid  out  1  IFU response strobe (1 cycle, no backpressure)
ifu_rsp_rdata  out  32  IFU read data
ifu_rsp_err  out  1  IFU decode/timeout error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted (1-cycle pulse)
lsu_req_wen  in  1  1 = write, 0 = read
lsu_req_addr  in  32  LSU address
lsu_req_wdata  in  32  LSU write data
lsu_req_wstrb  in  4  LSU byte strobes
lsu_rsp_valid  out  1  LSU response strobe (1 cycle)
lsu_rsp_rdata  out  32  LSU read data (0 for writes)
lsu_rsp_err  out  1  LSU decode/timeout error
m_req_valid  out  1  downstream request
m_req_ready  in  1  downstream accepts request
m_req_wen  out  1  downstream write enable
m_req_addr  out  32  latched address
m_req_wdata  out  32  latched write data
m_req_wstrb  out  4  latched strobes
m_rsp_valid  in  1  downstream response
m_rsp_rdata  in  32  downstream read data
xbar_decode  out  4  one-hot slave select: 0001 SRAM, 0010 UART, 0100 CLINT, 1000 unmapped

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = IFU, so the LSU wins the first tie.
- State IDLE
  - Only one requester valid: grant it.
  - Both valid: grant the requester not in last_grant.
  - The winner's req_ready pulses this cycle.
  - Latch addr/wen/wdata/wstrb; IFU grants force wen = 0.
  - Update last_grant.
  - Mapped address → ISSUE; unmapped → RESP with err = 1, rdata = 0, and no downstream request.
- State ISSUE
  - m_req_valid = 1 with latched fields, held stable until m_req_ready.
  - m_req_ready alone → WAIT.
  - m_req_ready and m_rsp_valid in the same cycle → RESP directly.
- State WAIT: on m_rsp_valid, latch m_rsp_rdata → RESP.
- State RESP
  - Owner's rsp_valid = 1 for exactly one cycle, with rdata and err.
  - For writes, rdata = 0.
  - Then → IDLE.
  - The non-owner's rsp_valid stays 0.
- xbar_decode
  - Driven from the latched address in ISSUE and WAIT only; 0000 otherwise.
  - Map ranges: SRAM 0x8000_0000–0x87FF_FFFF; UART 0xA000_03F8–0xA000_03FF; CLINT 0xA000_0048–0xA000_004F.
- Timing and ordering
  - Minimum latency: accept at cycle 0, m_req_valid at cycle 1, rsp_valid at cycle 2.
  - One outstanding transaction; no pipelining.
- m_rsp_valid outside ISSUE/WAIT is ignored (stale response dropped).
- Requesters hold req fields stable until ready; a requester that deasserts valid before grant is not served.
- Reset asserted mid-transaction: return to IDLE next cycle, no response issued, m_req_valid drops.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without m_rsp_valid → RESP with err = 1, rdata = 32'hDEAD_BEEF. A later downstream response is dropped.
- Undefined: no counter exists; WAIT persists until m_rsp_valid; err is set only for unmapped addresses.

Decomposition:
- macros.vh: decode base/limit constants, xbar_decode one-hot codes, state encodings (IDLE, ISSUE, WAIT, RESP), the error data pattern, and the ARB_TIMEOUT_EN switch.
- One sub-module: ysyx_22050499_addr_decode, purely combinational, 32-bit addr → 4-bit one-hot.
- FSM and arbitration stay in the top module.

Test Plan:
- IFU read 0x8000_0000, downstream ready and response same cycle with 0x1234_5678 → ifu_req_ready at c0, xbar_decode 0001 at c1, ifu_rsp_valid at c2 with rdata 0x1234_5678, err 0.
- Both valid simultaneously, three times after reset → grants LSU, IFU, LSU.
- LSU write 0xA000_03F8, wdata 0x41, wstrb 0001, m_req_ready delayed 3 cycles → m_req fields stable throughout, xbar_decode 0010, lsu_rsp_valid one cycle, rdata 0.
- LSU read 0x1000_0000 (unmapped) → m_req_valid never asserted, lsu_rsp_valid with err 1, rdata 0.
- With ARB_TIMEOUT_EN, no m_rsp_valid → rsp err 1, rdata 0xDEAD_BEEF after 16 WAIT cycles; a late m_rsp_valid is ignored.
- Reset pulse during WAIT → no rsp_valid, all outputs 0, and the next request is served normally.
